// File: rtl/fep_pkg.sv
// fep_pkg: shared constants, prefix layout and helpers for fep_strip.
// Prefix = 48-bit FEP tag over three little-endian 16-bit length copies.
package fep_pkg;

  localparam int HDR_BYTES = 12;
  localparam logic [47:0] FEP_HEADER = 48'h1eadfeb5ac0d;

  localparam int LEN0_LSB = 0;
  localparam int LEN1_LSB = 16;
  localparam int LEN2_LSB = 32;
  localparam int FEP_LSB  = 48;
  localparam int FEP_MSB  = 95;

  localparam int KEEP_W = 64;
  localparam int KCNT_W = 7;

  typedef struct packed {
    logic [47:0] tag;
    logic [15:0] len2;
    logic [15:0] len1;
    logic [15:0] len0;
  } fep_prefix_t;

  typedef enum logic [1:0] {
    HDR,
    BODY,
    FLUSH,
    DROP
  } state_t;

  function automatic logic [15:0] tmr_vote16(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [KCNT_W-1:0] keep_popcount(
    input logic [KEEP_W-1:0] keep
  );
    logic [KCNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      n = n + KCNT_W'(keep[i]);
    end
    return n;
  endfunction

  function automatic logic [KEEP_W-1:0] keep_mask(
    input logic [KCNT_W-1:0] n
  );
    logic [KEEP_W-1:0] m;
    for (int i = 0; i < KEEP_W; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

endpackage

// File: rtl/fep_realign.sv
// fep_realign: holds the upper 52 bytes of the previous beat and
// builds the realigned body/flush beats and their byte enables.
module fep_realign
  import fep_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    tail_set,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [KCNT_W-1:0]       in_k,
  output logic [DATA_WIDTH-1:0]   merged_data,
  output logic [DATA_WIDTH-1:0]   flush_data,
  output logic [DATA_WIDTH/8-1:0] last_keep,
  output logic [DATA_WIDTH/8-1:0] flush_keep
);

  localparam int PB = HDR_BYTES * 8;
  localparam int HW = DATA_WIDTH - PB;
  localparam int KW = DATA_WIDTH / 8;

  logic [HW-1:0]     hold;
  logic [KCNT_W-1:0] tail_k;

  // capture carried-over bytes and the final beat's byte count
  always_ff @(posedge clk) begin
    if (rst) begin
      hold   <= '0;
      tail_k <= '0;
    end else begin
      if (load) hold <= in_data[DATA_WIDTH-1:PB];
      if (tail_set) tail_k <= in_k;
    end
  end

  assign merged_data = {in_data[PB-1:0], hold};
  assign flush_data  = {{PB{1'b0}}, hold};
  assign last_keep   = keep_mask(in_k + KCNT_W'(KW - HDR_BYTES));
  assign flush_keep  = keep_mask(tail_k - KCNT_W'(HDR_BYTES));

endmodule

// File: rtl/fep_strip.sv
// fep_strip: validate FEP prefix, vote length, strip 12 bytes, realign.
// Optional length check enabled by defining FEP_STRIP_LEN_CHECK_EN.
module fep_strip
  import fep_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [CNT_WIDTH-1:0]    pkt_cnt,
  output logic [CNT_WIDTH-1:0]    hdr_drop_cnt,
  output logic [CNT_WIDTH-1:0]    tmr_fix_cnt,
  output logic [CNT_WIDTH-1:0]    len_err_cnt
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int PB = HDR_BYTES * 8;

  state_t            state, nstate;
  fep_prefix_t       pre;
  logic [KCNT_W-1:0] k;
  logic              acc, adv, tag_ok;
  logic              tmr_diff, last_small;
  logic              emit, e_flush, e_last, e_user;
  logic              load, tail_set;
  logic              drop_inc, tmr_inc;
  logic              len_bad, err_q;

  logic [DATA_WIDTH-1:0] merged_data, flush_data;
  logic [KW-1:0]         last_keep, flush_keep;

  assign pre        = fep_prefix_t'(s_axis_tdata[PB-1:0]);
  assign k          = keep_popcount(s_axis_tkeep);
  assign tag_ok     = pre.tag == FEP_HEADER;
  assign tmr_diff   = (pre.len0 != pre.len1)
                   || (pre.len1 != pre.len2);
  assign last_small = k <= KCNT_W'(HDR_BYTES);

  assign adv = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == DROP)
                      || ((state != FLUSH) && adv);
  assign acc = s_axis_tvalid && s_axis_tready;

  fep_realign #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_realign (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .tail_set    (tail_set),
    .in_data     (s_axis_tdata),
    .in_k        (k),
    .merged_data (merged_data),
    .flush_data  (flush_data),
    .last_keep   (last_keep),
    .flush_keep  (flush_keep)
  );

  // next state and per-cycle emit/load decisions
  always_comb begin
    nstate   = state;
    emit     = 1'b0;
    e_flush  = 1'b0;
    e_last   = 1'b0;
    e_user   = 1'b0;
    load     = 1'b0;
    tail_set = 1'b0;
    drop_inc = 1'b0;
    tmr_inc  = 1'b0;
    unique case (state)
      HDR: begin
        if (acc) begin
          if (!tag_ok) begin
            drop_inc = 1'b1;
            nstate   = s_axis_tlast ? HDR : DROP;
          end else begin
            tmr_inc = tmr_diff;
            load    = 1'b1;
            if (!s_axis_tlast) begin
              nstate = BODY;
            end else if (!last_small) begin
              tail_set = 1'b1;
              nstate   = FLUSH;
            end
          end
        end
      end
      BODY: begin
        if (acc) begin
          emit = 1'b1;
          load = 1'b1;
          if (s_axis_tlast) begin
            if (last_small) begin
              e_last = 1'b1;
              e_user = len_bad;
              nstate = HDR;
            end else begin
              tail_set = 1'b1;
              nstate   = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          emit    = 1'b1;
          e_flush = 1'b1;
          e_last  = 1'b1;
          e_user  = err_q;
          nstate  = HDR;
        end
      end
      DROP: begin
        if (acc && s_axis_tlast) nstate = HDR;
      end
      default: nstate = HDR;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= HDR;
    else state <= nstate;
  end

  // single output register stage toward AMPER
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
    end else if (adv) begin
      m_axis_tvalid <= emit;
      m_axis_tlast  <= e_last;
      m_axis_tuser  <= e_user;
      m_axis_tdata  <= e_flush ? flush_data : merged_data;
      if (e_flush) m_axis_tkeep <= flush_keep;
      else if (e_last) m_axis_tkeep <= last_keep;
      else m_axis_tkeep <= '1;
    end
  end

  // packet, drop and vote-repair statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt      <= '0;
      hdr_drop_cnt <= '0;
      tmr_fix_cnt  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
        pkt_cnt <= pkt_cnt + 1'b1;
      if (drop_inc) hdr_drop_cnt <= hdr_drop_cnt + 1'b1;
      if (tmr_inc) tmr_fix_cnt <= tmr_fix_cnt + 1'b1;
    end
  end

`ifdef FEP_STRIP_LEN_CHECK_EN
  logic [15:0]          vlen, vlen_q, acc_q;
  logic [15:0]          total, cmp_len;
  logic                 chk, lerr_inc;
  logic [CNT_WIDTH-1:0] lerr_q;

  assign vlen    = tmr_vote16(pre.len0, pre.len1, pre.len2);
  assign total   = (state == HDR ? 16'd0 : acc_q) + 16'(k);
  assign cmp_len = (state == HDR) ? vlen : vlen_q;
  assign len_bad = total != cmp_len;
  assign chk     = acc && s_axis_tlast
                && ((state == BODY)
                 || ((state == HDR) && tag_ok));
  assign lerr_inc = chk
                 && (len_bad || ((state == HDR) && last_small));

  // running byte total, voted length and pending flush error
  always_ff @(posedge clk) begin
    if (rst) begin
      vlen_q <= '0;
      acc_q  <= '0;
      err_q  <= 1'b0;
      lerr_q <= '0;
    end else begin
      if (acc) acc_q <= total;
      if (acc && (state == HDR)) vlen_q <= vlen;
      if (tail_set) err_q <= len_bad;
      if (lerr_inc) lerr_q <= lerr_q + 1'b1;
    end
  end

  assign len_err_cnt = lerr_q;
`else
  assign len_bad     = 1'b0;
  assign err_q       = 1'b0;
  assign len_err_cnt = '0;
`endif

endmodule

// File: doc/fep_strip.md
Name: fep_strip

Overview:
- Consumes the AXI4-Stream that the DDR ingress buffer replays toward AMPER.
- Validates the 12-byte in-band prefix on each packet's first beat: 48-bit FEP_HEADER plus three 16-bit copies of the packet length.
- Majority-votes the length, strips the prefix and byte-realigns the payload down by 12 bytes.
- Emits a clean AXIS frame with correct tkeep/tlast to AMPER. Flags length mismatches; drops packets without a valid FEP header.

Parameters:
- DATA_WIDTH, 512, stream width in bits; byte 0 = tdata[7:0].
- HDR_BYTES, 12, prefix bytes removed; fixed by the prefix format.
- FEP_HEADER, 48'h1eadfeb5ac0d, expected tag in first-beat bits [95:48].
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_axis_tdata  in  DATA_WIDTH  input beat
- s_axis_tkeep  in  DATA_WIDTH/8  contiguous-low byte enables
- s_axis_tlast  in  1  last beat of packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  DATA_WIDTH  realigned payload
- m_axis_tkeep  out  DATA_WIDTH/8  output byte enables
- m_axis_tlast  out  1  last output beat
- m_axis_tuser  out  1  length-error flag, valid with tlast
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  AMPER ready
- pkt_cnt  out  CNT_WIDTH  packets forwarded
- hdr_drop_cnt  out  CNT_WIDTH  packets dropped for FEP mismatch
- tmr_fix_cnt  out  CNT_WIDTH  packets whose three length copies disagreed
- len_err_cnt  out  CNT_WIDTH  packets whose byte count differs from the voted length

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. All outputs 0 on reset: tvalid, tlast, tuser, tkeep, tdata and all counters. State goes to HDR.
- rst mid-packet discards the partial packet. After reset the next accepted beat is treated as a header beat.
- Output is one register stage.
- s_axis_tready = (state != FLUSH) && (!m_axis_tvalid || m_axis_tready). In DROP, tready = 1.
- Length copies: L0 = [15:0], L1 = [31:16], L2 = [47:32]. Vlen = bitwise majority. tmr_fix_cnt++ if any copy differs.
- Byte accumulator: 16-bit, sums popcount(tkeep) over the packet's input beats.
- State HDR, on accepted beat:
  - FEP mismatch: hdr_drop_cnt++. Go to DROP, or stay in HDR if tlast.
  - FEP match: latch Vlen and hold = bytes 12..63. Go to BODY.
  - FEP match with tlast and k = popcount(tkeep): if k > 12, go to FLUSH. If k ≤ 12, the packet has zero payload: no output, len_err_cnt++.
- State BODY, on accepted beat: emit {in bytes 0..11, hold} as 64 bytes, then hold = in bytes 12..63.
  - On tlast with k ≤ 12: the emitted beat has keep = 52 + k low bits and tlast=1. Go to HDR.
  - On tlast with k > 12: the emitted beat is full, tlast=0. Go to FLUSH.
- State FLUSH: emit hold with keep = (k − 12) low bits and tlast=1. Go to HDR when accepted.
- DROP: consume beats silently until tlast, then go to HDR.
- pkt_cnt++ when the tlast beat is handed off (tvalid && tready).
- Back-to-back packets need no bubble, except the FLUSH cycle.
- Output data bytes outside tkeep are don't-care.

Optional Feature:
- Macro FEP_STRIP_LEN_CHECK_EN.
- Defined: at tlast, compare the accumulator with Vlen. On mismatch, m_axis_tuser = 1 on the last output beat and len_err_cnt++.
- Undefined: no accumulator or comparator. m_axis_tuser and len_err_cnt are constant 0, including the zero-payload case.

Decomposition:
- Shared package fep_pkg holds:
  - FEP_HEADER, HDR_BYTES, and field offsets (LEN0/1/2, FEP bit ranges).
  - A fep_prefix_t packed struct.
  - Function tmr_vote16.
  - Function keep_popcount.
- One natural sub-module: fep_realign. It holds the hold register and builds merged/flush data plus tkeep. The FSM and counters stay in fep_strip.

Test Plan:
- 128-byte packet (2 beats, full keep), lengths 0x0080 ×3 → 2 output beats: full keep, then keep = 52 low bits with tlast. tuser=0, pkt_cnt=1.
- 70-byte packet (beat 2 k=6) → 1 output beat, keep = 58 low bits, tlast, bytes = input bytes 12..69.
- 64-byte single-beat packet, Vlen = 64 → FLUSH beat with keep = 52 low bits. s_axis_tready low during FLUSH.
- FEP tag 48'h0 on a 3-beat packet → no output, hdr_drop_cnt=1, s_axis_tready high all 3 beats.
- Copies 0x0080/0x0080/0x0480 on 128 bytes → Vlen = 0x0080, tmr_fix_cnt=1, tuser=0. Copies 0x00C8 ×3 on 128 bytes → tuser=1 on last beat, len_err_cnt=1.
- 50 random packets (64–1518 B) back-to-back, m_axis_tready randomized at 50% → output matches the reference model byte-for-byte, counters consistent, no loss or duplication.
